// File: rtl/y_stream_packer.sv
// Packs WIDTH qualified samples of the detector output y into words, counts their ones,
// and offers each word on a valid/ready port with a sticky overrun flag for dropped words.
module y_stream_packer #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             y,
    input  logic             y_en,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_ones,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int NW = $clog2(WIDTH);
    localparam logic [NW-1:0] LAST = NW'(WIDTH - 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // Bit 0 of the shift register would be shifted out on the completing edge before
    // ever being read, so only the upper WIDTH-1 bits are kept.
    logic [WIDTH-1:1] sr;
    logic [NW-1:0]    cnt;
    logic [CW-1:0]    acc;
    logic [0:0]       state;

    logic             complete;
    logic [WIDTH-1:0] next_word;
    logic [CW-1:0]    next_ones;

    assign complete  = y_en && (cnt == LAST);
    assign next_word = {y, sr[WIDTH-1:1]};
    assign next_ones = acc + CW'(y);
    assign out_valid = (state == FULL);

    always_ff @(posedge clock) begin
        if (reset) begin
            sr       <= '0;
            cnt      <= '0;
            acc      <= '0;
            state    <= EMPTY;
            out_data <= '0;
            out_ones <= '0;
            overrun  <= 1'b0;
        end else begin
            if (y_en) begin
                sr <= next_word[WIDTH-1:1];
                if (complete) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + NW'(1);
                    acc <= next_ones;
                end
            end

            // A full register only accepts a new word if the old one leaves on the same edge.
            case (state)
                EMPTY: begin
                    if (complete) begin
                        out_data <= next_word;
                        out_ones <= next_ones;
                        state    <= FULL;
                    end
                end
                default: begin
                    if (complete) begin
                        if (out_ready) begin
                            out_data <= next_word;
                            out_ones <= next_ones;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y_stream_packer.sv
// Directed table-driven bench for y_stream_packer (WIDTH=8): each vector is one clock
// edge of stimulus followed by the outputs expected just after that edge.
module tb_y_stream_packer;

    logic       clock = 1'b0;
    logic       reset;
    logic       y;
    logic       y_en;
    logic [7:0] out_data;
    logic [3:0] out_ones;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       yb;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] eo;
        logic       eov;
    } vec_t;

    vec_t vecs[$];

    y_stream_packer #(.WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .y        (y),
        .y_en     (y_en),
        .out_data (out_data),
        .out_ones (out_ones),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    // Drive one edge worth of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic yb, input logic rdy);
        reset     = rst;
        y_en      = en;
        y         = yb;
        out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [7:0] ed,
                               input logic [3:0] eo, input logic eov);
        total++;
        if (out_valid !== ev || out_data !== ed || out_ones !== eo || overrun !== eov) begin
            bad++;
            $display("[TB] FAIL %s: got valid=%b data=%h ones=%0d overrun=%b, want valid=%b data=%h ones=%0d overrun=%b",
                     name, out_valid, out_data, out_ones, overrun, ev, ed, eo, eov);
        end
    endtask

    task automatic addVec(input logic rst, input logic en, input logic yb, input logic rdy,
                          input logic ev, input logic [7:0] ed, input logic [3:0] eo, input logic eov);
        vec_t v;
        v.rst = rst; v.en = en; v.yb = yb; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.eo = eo; v.eov = eov;
        vecs.push_back(v);
    endtask

    // Eight samples of w (bit 0 first); the first seven edges expect the "hold" outputs,
    // the completing edge expects the "fin" outputs and uses its own ready value.
    task automatic addWord(input logic [7:0] w, input logic rdy, input logic rdy_last,
                           input logic hv, input logic [7:0] hd, input logic [3:0] ho, input logic hov,
                           input logic fv, input logic [7:0] fd, input logic [3:0] fo, input logic fov);
        for (int i = 0; i < 7; i++) addVec(1'b0, 1'b1, w[i], rdy, hv, hd, ho, hov);
        addVec(1'b0, 1'b1, w[7], rdy_last, fv, fd, fo, fov);
    endtask

    initial begin
        // Reset and basic pack, held until ready, then released.
        addVec(1, 0, 0, 0, 0, 8'h00, 0, 0);
        addWord(8'h8D, 0, 0, 0, 8'h00, 0, 0, 1, 8'h8D, 4, 0);
        addVec(0, 0, 0, 0, 1, 8'h8D, 4, 0);
        addVec(0, 0, 1, 0, 1, 8'h8D, 4, 0);
        addVec(0, 0, 0, 1, 0, 8'h8D, 4, 0);

        // Gapped samples; ready during gaps while empty must do nothing.
        addVec(0, 1, 1, 0, 0, 8'h8D, 4, 0);
        addVec(0, 1, 0, 0, 0, 8'h8D, 4, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, 1, 1, 0, 8'h8D, 4, 0);
        addVec(0, 1, 1, 0, 0, 8'h8D, 4, 0);
        addVec(0, 1, 1, 0, 0, 8'h8D, 4, 0);
        addVec(0, 1, 0, 0, 0, 8'h8D, 4, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, 8'h8D, 4, 0);
        addVec(0, 1, 0, 0, 0, 8'h8D, 4, 0);
        addVec(0, 1, 0, 0, 0, 8'h8D, 4, 0);
        addVec(0, 1, 1, 0, 1, 8'h8D, 4, 0);
        addVec(0, 0, 0, 1, 0, 8'h8D, 4, 0);

        // Overrun: second word dropped, old word kept, flag sticky after handshake.
        addWord(8'h0F, 0, 0, 0, 8'h8D, 4, 0, 1, 8'h0F, 4, 0);
        addWord(8'hF0, 0, 0, 1, 8'h0F, 4, 0, 1, 8'h0F, 4, 1);
        addVec(0, 0, 0, 1, 0, 8'h0F, 4, 1);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 5; i++) addVec(0, 1, 1, 0, 0, 8'h0F, 4, 1);
        addVec(1, 0, 0, 0, 0, 8'h00, 0, 0);
        addWord(8'h3C, 0, 0, 0, 8'h00, 0, 0, 1, 8'h3C, 4, 0);

        // Completion on the same edge as the handshake keeps valid high.
        addWord(8'h81, 0, 1, 1, 8'h3C, 4, 0, 1, 8'h81, 2, 0);
        addVec(0, 0, 0, 1, 0, 8'h81, 2, 0);

        reset = 1'b1; y_en = 1'b0; y = 1'b0; out_ready = 1'b0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].yb, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eo, vecs[i].eov);
        end

        // Hand-written: back-to-back words with ready held high.
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 1);
        checkOutput("b2b_first", 1, 8'hFF, 8, 0);
        begin
            logic [7:0] aa;
            aa = 8'hAA;
            applyStimulus(0, 1, aa[0], 1);
            checkOutput("b2b_drain", 0, 8'hFF, 8, 0);
            for (int i = 1; i < 8; i++) applyStimulus(0, 1, aa[i], 1);
            checkOutput("b2b_second", 1, 8'hAA, 4, 0);
        end

        // Hand-written: reset while a word is held and overrun is set, with y_en/ready high.
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("hold_overrun", 1, 8'hAA, 4, 1);
        applyStimulus(1, 1, 1, 1);
        checkOutput("reset_hold", 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0);
        checkOutput("post_reset_partial", 0, 8'h00, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("post_reset_word", 1, 8'h7F, 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
